// File: rtl/moldudp64_pkg.sv
// Shared definitions for the MoldUDP64 encoder: FSM encoding, header layout
// and the message counts that mark heartbeat / end-of-session packets.
package moldudp64_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR0  = 3'd1,
    HDR1  = 3'd2,
    HDR2  = 3'd3,
    BODY  = 3'd4,
    FLUSH = 3'd5
  } state_e;

  localparam int unsigned HDR_BYTES   = 20;
  localparam int unsigned SESSION_OFS = 0;
  localparam int unsigned SEQ_OFS     = 10;
  localparam int unsigned COUNT_OFS   = 18;

  localparam logic [15:0] HEARTBEAT      = 16'h0000;
  localparam logic [15:0] END_OF_SESSION = 16'hFFFF;

  // Keeps the low nbytes byte lanes of a 32-bit word (nbytes >= 4 keeps all).
  function automatic logic [31:0] lane_mask32(input logic [3:0] nbytes);
    logic [31:0] m;
    m = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      if (nbytes > 4'(i)) begin
        m[8*i +: 8] = 8'hFF;
      end else begin
        m[8*i +: 8] = 8'h00;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/moldudp64_encoder.sv
// MoldUDP64 packet encoder: prepends the 20-byte header to a payload stream,
// realigning the payload by 4 bytes through a 32-bit residual register.
module moldudp64_encoder
  import moldudp64_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start_valid,
  output logic        o_start_ready,
  input  logic [79:0] i_session_id,
  input  logic [63:0] i_sequence_number,
  input  logic [15:0] i_message_count,
  input  logic [63:0] i_in_data,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic        i_in_last,
  input  logic [3:0]  i_in_bytes,
  output logic [63:0] o_out_data,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic        o_out_last,
  output logic [3:0]  o_out_bytes
);

  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_HDR0  = HDR0;
  localparam logic [2:0] S_HDR1  = HDR1;
  localparam logic [2:0] S_HDR2  = HDR2;
  localparam logic [2:0] S_BODY  = BODY;
  localparam logic [2:0] S_FLUSH = FLUSH;

  logic [2:0]  r_state;
  logic [79:0] r_session;
  logic [63:0] r_seq;
  logic [15:0] r_count;
  logic [31:0] r_resid;
  logic [3:0]  r_flush_bytes;
  logic [63:0] r_out_data;
  logic        r_out_valid;
  logic        r_out_last;
  logic [3:0]  r_out_bytes;

  logic [8*HDR_BYTES-1:0] w_hdr;
  logic        w_load;
  logic        w_special;
  logic        w_in_fire;
  logic        w_short_last;
  logic [31:0] w_resid_src;
  logic [31:0] w_lo;
  logic [63:0] w_pay_beat;
  logic        w_latch;
  logic        w_emit;
  logic [63:0] w_nxt_data;
  logic [3:0]  w_nxt_bytes;
  logic        w_nxt_last;
  logic [2:0]  w_nxt_state;

  assign w_load    = ~r_out_valid | i_out_ready;
  assign w_special = (r_count == HEARTBEAT) | (r_count == END_OF_SESSION);

  assign o_start_ready = ~rst & (r_state == S_IDLE);
  assign o_in_ready    = ~rst & w_load &
                         (((r_state == S_HDR2) & ~w_special) | (r_state == S_BODY));
  assign w_in_fire     = o_in_ready & i_in_valid;

  assign o_out_valid = r_out_valid & ~rst;
  assign o_out_last  = r_out_last & ~rst;
  assign o_out_data  = r_out_data;
  assign o_out_bytes = r_out_bytes;

  // Header image, byte 0 in the least significant lane.
  always_comb begin
    w_hdr = '0;
    w_hdr[8*SESSION_OFS +: 80] = r_session;
    w_hdr[8*SEQ_OFS     +: 64] = r_seq;
    w_hdr[8*COUNT_OFS   +: 16] = r_count;
  end

  // Payload beat: low half of the new word on top of the carried residual.
  always_comb begin
    w_resid_src  = (r_state == S_HDR2) ? w_hdr[8*(HDR_BYTES-4) +: 32] : r_resid;
    w_short_last = i_in_last & (i_in_bytes <= 4'd4);
    w_lo         = w_short_last ? (i_in_data[31:0] & lane_mask32(i_in_bytes))
                                : i_in_data[31:0];
    w_pay_beat   = {w_lo, w_resid_src};
  end

  // Next-state and next-beat selection.
  always_comb begin
    w_latch     = 1'b0;
    w_emit      = 1'b0;
    w_nxt_data  = 64'h0;
    w_nxt_bytes = 4'd8;
    w_nxt_last  = 1'b0;
    w_nxt_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start_valid) begin
          w_latch = 1'b1;
          if (w_load) begin
            w_emit      = 1'b1;
            w_nxt_data  = i_session_id[63:0];
            w_nxt_state = S_HDR1;
          end else begin
            w_nxt_state = S_HDR0;
          end
        end else begin
          w_nxt_state = S_IDLE;
        end
      end
      S_HDR0: begin
        if (w_load) begin
          w_emit      = 1'b1;
          w_nxt_data  = w_hdr[63:0];
          w_nxt_state = S_HDR1;
        end else begin
          w_nxt_state = S_HDR0;
        end
      end
      S_HDR1: begin
        if (w_load) begin
          w_emit      = 1'b1;
          w_nxt_data  = w_hdr[127:64];
          w_nxt_state = S_HDR2;
        end else begin
          w_nxt_state = S_HDR1;
        end
      end
      S_HDR2, S_BODY: begin
        if ((r_state == S_HDR2) && w_special) begin
          if (w_load) begin
            w_emit      = 1'b1;
            w_nxt_data  = {32'h0, w_hdr[8*(HDR_BYTES-4) +: 32]};
            w_nxt_bytes = 4'd4;
            w_nxt_last  = 1'b1;
            w_nxt_state = S_IDLE;
          end else begin
            w_nxt_state = r_state;
          end
        end else if (w_in_fire) begin
          w_emit     = 1'b1;
          w_nxt_data = w_pay_beat;
          if (!i_in_last) begin
            w_nxt_state = S_BODY;
          end else if (w_short_last) begin
            w_nxt_bytes = 4'd4 + i_in_bytes;
            w_nxt_last  = 1'b1;
            w_nxt_state = S_IDLE;
          end else begin
            w_nxt_state = S_FLUSH;
          end
        end else begin
          w_nxt_state = r_state;
        end
      end
      S_FLUSH: begin
        if (w_load) begin
          w_emit      = 1'b1;
          w_nxt_data  = {32'h0, r_resid};
          w_nxt_bytes = r_flush_bytes;
          w_nxt_last  = 1'b1;
          w_nxt_state = S_IDLE;
        end else begin
          w_nxt_state = S_FLUSH;
        end
      end
      default: begin
        w_nxt_state = S_IDLE;
      end
    endcase
  end

  // State, latched fields, residual and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_session     <= 80'h0;
      r_seq         <= 64'h0;
      r_count       <= 16'h0;
      r_resid       <= 32'h0;
      r_flush_bytes <= 4'd0;
      r_out_data    <= 64'h0;
      r_out_valid   <= 1'b0;
      r_out_last    <= 1'b0;
      r_out_bytes   <= 4'd0;
    end else begin
      r_state <= w_nxt_state;
      if (w_latch) begin
        r_session <= i_session_id;
        r_seq     <= i_sequence_number;
        r_count   <= i_message_count;
      end
      // A long last beat leaves in_bytes-4 bytes behind for the flush beat.
      if (w_in_fire) begin
        r_resid       <= i_in_last ? (i_in_data[63:32] & lane_mask32(i_in_bytes - 4'd4))
                                   : i_in_data[63:32];
        r_flush_bytes <= i_in_bytes - 4'd4;
      end
      if (w_emit) begin
        r_out_data  <= w_nxt_data;
        r_out_bytes <= w_nxt_bytes;
        r_out_last  <= w_nxt_last;
        r_out_valid <= 1'b1;
      end else if (w_load) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_moldudp64_encoder.sv
// Scoreboard bench for moldudp64_encoder: directed packets with hand-computed
// beats, a mid-packet reset, and throttled random packets against a byte model.
module tb_moldudp64_encoder;

  typedef struct packed {
    logic [63:0] d;
    logic [3:0]  b;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start_valid;
  logic        o_start_ready;
  logic [79:0] i_session_id;
  logic [63:0] i_sequence_number;
  logic [15:0] i_message_count;
  logic [63:0] i_in_data;
  logic        i_in_valid;
  logic        o_in_ready;
  logic        i_in_last;
  logic [3:0]  i_in_bytes;
  logic [63:0] o_out_data;
  logic        o_out_valid;
  logic        i_out_ready;
  logic        o_out_last;
  logic [3:0]  o_out_bytes;

  beat_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        throttle = 1'b0;
  logic [63:0] pay[16];
  int          inrdy_cnt = 0;
  beat_t       prev_beat;
  logic        prev_stall = 1'b0;

  moldudp64_encoder dut (
    .clk(clk), .rst(rst),
    .i_start_valid(i_start_valid), .o_start_ready(o_start_ready),
    .i_session_id(i_session_id), .i_sequence_number(i_sequence_number),
    .i_message_count(i_message_count),
    .i_in_data(i_in_data), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_in_last(i_in_last), .i_in_bytes(i_in_bytes),
    .o_out_data(o_out_data), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_out_last(o_out_last), .o_out_bytes(o_out_bytes)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Sink-side ready: held high, or a coin flip per cycle when throttling.
  initial begin
    i_out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      i_out_ready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: stall stability and scoreboard pop on every output transfer.
  always @(negedge clk) begin
    beat_t cur;
    beat_t e;
    cur = {o_out_data, o_out_bytes, o_out_last};
    if (o_in_ready) inrdy_cnt++;
    if (prev_stall && !rst) begin
      checks++;
      if (o_out_valid !== 1'b1 || cur !== prev_beat) begin
        errors++;
        $display("FAIL stall_stable got v=%b %h want v=1 %h", o_out_valid, cur, prev_beat);
      end
    end
    if (o_out_valid && i_out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL extra_beat got data=%h bytes=%0d last=%b want none",
                 o_out_data, o_out_bytes, o_out_last);
      end else begin
        e = exp_q.pop_front();
        if (cur !== e) begin
          errors++;
          $display("FAIL beat got data=%h bytes=%0d last=%b want data=%h bytes=%0d last=%b",
                   o_out_data, o_out_bytes, o_out_last, e.d, e.b, e.l);
        end
      end
    end
    prev_stall = o_out_valid && !i_out_ready && !rst;
    prev_beat  = cur;
  end

  task automatic chk(input string nm, input logic [79:0] got, input logic [79:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  task automatic push_exp(input logic [63:0] d, input logic [3:0] b, input logic l);
    exp_q.push_back({d, b, l});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: flatten header + payload into bytes, then cut into 8-byte beats.
  task automatic gen_ref(input logic [79:0] s, input logic [63:0] q, input logic [15:0] c,
                         input int np, input logic [3:0] lb);
    logic [7:0]   bq[$];
    logic [159:0] h;
    logic [63:0]  d;
    int           nb;
    h = {c, q, s};
    for (int i = 0; i < 20; i++) bq.push_back(h[8*i +: 8]);
    if (c != 16'h0000 && c != 16'hFFFF) begin
      for (int k = 0; k < np; k++) begin
        nb = (k == np - 1) ? int'(lb) : 8;
        for (int i = 0; i < nb; i++) bq.push_back(pay[k][8*i +: 8]);
      end
    end
    while (bq.size() > 0) begin
      d  = 64'h0;
      nb = 0;
      for (int i = 0; i < 8; i++) begin
        if (bq.size() > 0) begin
          d[8*i +: 8] = bq.pop_front();
          nb++;
        end
      end
      push_exp(d, 4'(nb), bq.size() == 0);
    end
  endtask

  task automatic drive_pkt(input logic [79:0] s, input logic [63:0] q, input logic [15:0] c,
                           input int np, input logic [3:0] lb, input int abort_n,
                           input bit chk_lat, input bit gaps);
    int n;
    i_session_id      = s;
    i_sequence_number = q;
    i_message_count   = c;
    i_start_valid     = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (o_start_ready) break;
      n++;
      if (n > 2000) begin
        checks++;
        errors++;
        $display("FAIL start_timeout got ready=0 want ready=1");
        i_start_valid = 1'b0;
        return;
      end
    end
    tick();
    i_start_valid = 1'b0;
    if (chk_lat) begin
      @(negedge clk);
      chk("first_hdr_latency", 80'(o_out_valid), 80'h1);
      tick();
    end
    if (c == 16'h0000 || c == 16'hFFFF) return;
    for (int k = 0; k < np && k < abort_n; k++) begin
      if (gaps) repeat ($urandom_range(0, 1)) tick();
      i_in_data  = pay[k];
      i_in_last  = (k == np - 1);
      i_in_bytes = (k == np - 1) ? lb : 4'd8;
      i_in_valid = 1'b1;
      n = 0;
      while (1) begin
        @(negedge clk);
        if (o_in_ready) break;
        n++;
        if (n > 2000) begin
          checks++;
          errors++;
          $display("FAIL payload_timeout got in_ready=0 want in_ready=1");
          i_in_valid = 1'b0;
          return;
        end
      end
      tick();
      i_in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    repeat (2) tick();
    chk("drain_queue_empty", 80'(exp_q.size()), 80'h0);
  endtask

  initial begin
    logic [79:0] s;
    logic [63:0] q;
    logic [15:0] c;
    int          np;
    int          r;
    int          r0;
    logic [3:0]  lb;

    rst = 1'b1;
    i_start_valid = 1'b0;
    i_session_id = 80'h0;
    i_sequence_number = 64'h0;
    i_message_count = 16'h0;
    i_in_data = 64'h0;
    i_in_valid = 1'b0;
    i_in_last = 1'b0;
    i_in_bytes = 4'd0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_out_valid", 80'(o_out_valid), 80'h0);
    chk("rst_start_ready", 80'(o_start_ready), 80'h0);
    chk("rst_in_ready", 80'(o_in_ready), 80'h0);
    chk("rst_out_data", 80'(o_out_data), 80'h0);
    chk("rst_out_bytes", 80'(o_out_bytes), 80'h0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("start_ready_after_rst", 80'(o_start_ready), 80'h1);
    tick();

    // Heartbeat: header only, last beat carries count + seq[63:48].
    r0 = inrdy_cnt;
    push_exp(64'h030405060708090A, 4'd8, 1'b0);
    push_exp(64'h0000000000050102, 4'd8, 1'b0);
    push_exp(64'h0000000000000000, 4'd4, 1'b1);
    drive_pkt(80'h0102030405060708090A, 64'h5, 16'h0000, 0, 4'd1, 0, 1'b1, 1'b0);
    wait_drain();
    chk("heartbeat_no_in_ready", 80'(inrdy_cnt - r0), 80'h0);

    // One short payload beat (2 bytes).
    pay[0] = 64'h1122334455667788;
    push_exp(64'hA2A3A4A5A6A7A8A9, 4'd8, 1'b0);
    push_exp(64'h121314151617A0A1, 4'd8, 1'b0);
    push_exp(64'h0000778800011011, 4'd6, 1'b1);
    drive_pkt(80'hA0A1A2A3A4A5A6A7A8A9, 64'h1011121314151617, 16'h0001, 1, 4'd2, 1, 1'b1, 1'b0);
    wait_drain();

    // Two payload beats, last with 7 bytes -> flush beat with 3 bytes.
    pay[0] = 64'h0706050403020100;
    pay[1] = 64'h0F0E0D0C0B0A0908;
    push_exp(64'h0000000000000000, 4'd8, 1'b0);
    push_exp(64'hDDCCBBAA99880000, 4'd8, 1'b0);
    push_exp(64'h030201000002FFEE, 4'd8, 1'b0);
    push_exp(64'h0B0A090807060504, 4'd8, 1'b0);
    push_exp(64'h00000000000E0D0C, 4'd3, 1'b1);
    drive_pkt(80'h0, 64'hFFEEDDCCBBAA9988, 16'h0002, 2, 4'd7, 2, 1'b1, 1'b0);
    wait_drain();

    // End of session.
    push_exp(64'h0000000000000001, 4'd8, 1'b0);
    push_exp(64'h0000000000020000, 4'd8, 1'b0);
    push_exp(64'h00000000FFFF0000, 4'd4, 1'b1);
    drive_pkt(80'h1, 64'h2, 16'hFFFF, 0, 4'd1, 0, 1'b1, 1'b0);
    wait_drain();

    // Last beat with exactly 4 bytes: no flush.
    pay[0] = 64'hDEADBEEFCAFEF00D;
    push_exp(64'h0000000000000000, 4'd8, 1'b0);
    push_exp(64'h0000000000000000, 4'd8, 1'b0);
    push_exp(64'hCAFEF00D00030000, 4'd8, 1'b1);
    drive_pkt(80'h0, 64'h0, 16'h0003, 1, 4'd4, 1, 1'b1, 1'b0);
    wait_drain();

    // Reset in BODY with a beat pending.
    for (int k = 0; k < 4; k++) pay[k] = {32'h5A5A0000 + 32'(k), 32'hC3C30000 + 32'(k)};
    gen_ref(80'h77, 64'h88, 16'h0004, 4, 4'd8);
    drive_pkt(80'h77, 64'h88, 16'h0004, 4, 4'd8, 2, 1'b0, 1'b0);
    chk("pre_rst_out_valid", 80'(o_out_valid), 80'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", 80'(o_out_valid), 80'h0);
    tick();
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("post_rst_out_valid", 80'(o_out_valid), 80'h0);
    chk("post_rst_start_ready", 80'(o_start_ready), 80'h1);
    tick();
    pay[0] = 64'h1122334455667788;
    push_exp(64'hA2A3A4A5A6A7A8A9, 4'd8, 1'b0);
    push_exp(64'h121314151617A0A1, 4'd8, 1'b0);
    push_exp(64'h0000778800011011, 4'd6, 1'b1);
    drive_pkt(80'hA0A1A2A3A4A5A6A7A8A9, 64'h1011121314151617, 16'h0001, 1, 4'd2, 1, 1'b1, 1'b0);
    wait_drain();

    // Throttled random packets against the byte-stream model.
    throttle = 1'b1;
    for (int p = 0; p < 100; p++) begin
      s  = {16'($urandom), $urandom, $urandom};
      q  = {$urandom, $urandom};
      r  = $urandom_range(0, 9);
      c  = (r == 0) ? 16'h0000 : (r == 1) ? 16'hFFFF : 16'($urandom_range(1, 500));
      np = $urandom_range(1, 4);
      lb = 4'($urandom_range(1, 8));
      for (int k = 0; k < np; k++) pay[k] = {$urandom, $urandom};
      gen_ref(s, q, c, np, lb);
      drive_pkt(s, q, c, np, lb, np, 1'b0, 1'b1);
    end
    wait_drain();
    throttle = 1'b0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/moldudp64_encoder.md
MOLDUDP64_ENCODER -- requirements
Module: moldudp64_encoder

Interface
REQ-001 No parameters; all datapath widths are fixed as listed below.
REQ-002 clk  in  1  clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 start_valid / start_ready  in / out  1 / 1  packet request handshake; transfer when both are high.
REQ-005 session_id  in  80  session field, sampled on the start transfer.
REQ-006 sequence_number  in  64  sequence field, sampled on the start transfer.
REQ-007 message_count  in  16  count field, sampled on the start transfer.
REQ-008 in_data / in_valid / in_ready  in / in / out  64 / 1 / 1  payload beats (length-prefixed message blocks, pre-formatted upstream).
REQ-009 in_last / in_bytes  in / in  1 / 4  last payload beat; valid bytes in the last beat, range 1..8, ignored unless in_last.
REQ-010 out_data / out_valid / out_ready  out / out / in  64 / 1 / 1  packet beats, starting at MoldUDP64 header byte 0.
REQ-011 out_last / out_bytes  out / out  1 / 4  last beat; valid bytes in it (1..8; 8 on non-last beats).

Function
REQ-012 Byte lanes: packet byte k SHALL appear on out_data[8*(k%8)+7 : 8*(k%8)] of beat k/8; in_data uses the same lane order.
REQ-013 Header layout (20 bytes): bytes 0-9 = session_id, bytes 10-17 = sequence_number, bytes 18-19 = message_count; field byte n = field bits [8n+7:8n], so the least significant byte comes first.
REQ-014 FSM states: IDLE, HDR0, HDR1, HDR2, BODY, FLUSH.
REQ-015 IDLE: start_ready=1. On a start transfer, latch the three fields and go to HDR0. start_ready=0 in all other states.
REQ-016 Output register rule: a new beat loads only when out_valid=0 or out_ready=1. out_* SHALL hold stable while out_valid=1 and out_ready=0.
REQ-017 HDR0 emits header bytes 0-7. HDR1 emits header bytes 8-15. Each state advances when its beat loads.
REQ-018 If message_count is 0x0000 (heartbeat) or 0xFFFF (end of session), HDR2 SHALL emit header bytes 16-19 alone with out_bytes=4 and out_last=1, consume no payload, and return to IDLE.
REQ-019 Otherwise HDR2 and BODY assert in_ready = (out_valid=0 or out_ready=1). in_ready=0 in every other state.
REQ-020 Realignment: a 32-bit residual register holds in_data[63:32] of the previous payload beat. In HDR2 the residual source is header bytes 16-19.
REQ-021 On each accepted payload beat, the emitted beat = {in_data[31:0], residual}, and the residual is then updated.
REQ-022 Accepted beat with in_last=0: out_bytes=8, out_last=0; HDR2 moves to BODY.
REQ-023 Accepted beat with in_last=1 and in_bytes<=4: out_bytes=4+in_bytes, out_last=1, next state IDLE.
REQ-024 Accepted beat with in_last=1 and in_bytes>4: emit the beat with out_bytes=8, out_last=0, then go to FLUSH.
REQ-025 FLUSH emits {32'h0, residual} with out_bytes=in_bytes-4 and out_last=1, then goes to IDLE.
REQ-026 Unused bytes of the final beat SHALL be driven to zero.
REQ-027 Throughput: one beat per cycle with out_ready held high. A packet with a P-beat payload occupies P+2 output beats, or P+3 when a FLUSH beat is needed.
REQ-028 Latency: the first header beat is valid on the cycle after the start transfer.
REQ-029 A start request during an active packet SHALL wait; start_ready is low until the FSM is back in IDLE.

Reset
REQ-030 While rst=1, the FSM SHALL go to IDLE, and out_valid, out_last, start_ready and in_ready SHALL be 0.
REQ-031 While rst=1, out_data, out_bytes, the residual register and the latched fields SHALL be cleared to 0.
REQ-032 A reset mid-packet SHALL abandon the packet with no further beats. Input data already accepted is discarded.
REQ-033 start_ready SHALL be 1 on the first cycle after rst deasserts.

Structure
REQ-034 Package moldudp64_pkg SHALL hold the FSM state enum and HDR_BYTES=20.
REQ-035 moldudp64_pkg SHALL hold the header byte offsets: SESSION_OFS=0, SEQ_OFS=10, COUNT_OFS=18.
REQ-036 moldudp64_pkg SHALL hold the constants HEARTBEAT=16'h0000 and END_OF_SESSION=16'hFFFF.
REQ-037 Single flat module; no sub-module is required.

Verification
REQ-038 Heartbeat: session_id=80'h0102..0A, sequence_number=64'h5, message_count=0 -> 3 beats; beat 2 = 32'h0 + {count, seq[63:48]}, out_bytes=4, out_last=1; no in_ready pulse.
REQ-039 One payload beat 64'h1122334455667788 with in_last=1, in_bytes=2, message_count=1 -> beat 2 = {16'h0, 16'h7788, hdr[19:16]}, out_bytes=6, out_last=1.
REQ-040 Payload of 2 beats, last with in_bytes=7 -> 5 output beats; beat 4 out_bytes=3, out_last=1, upper bytes zero.
REQ-041 Random out_ready throttling at 50% over 100 packets -> output equals the reference byte stream; out_* is stable while stalled; no beat is lost or duplicated.
REQ-042 rst asserted in BODY with out_valid=1 -> next cycle out_valid=0, start_ready=1; the next packet is emitted cleanly from header byte 0.
